pll_reset_ctrl: RTL
===================

Name: pll_reset_ctrl

Overview:
Controller for the iCE40 PLL primitive. It drives the PLL's active-low reset and consumes its LOCK output. It sequences PLL reset, waits for lock, and qualifies lock as stable. Only then does it release the system reset for downstream logic. Runs on the raw board reference clock, never on the PLL output. It recovers automatically from lock loss, lock timeout and software relock requests.

Parameters:
RESET_CYCLES, 16, cycles the PLL is held in reset (pll_resetb=0) per attempt; must be >=1.
LOCK_TIMEOUT, 4096, max cycles in WAIT_LOCK before re-resetting the PLL; must be >=2.
STABLE_CYCLES, 256, consecutive synchronized-lock cycles required before releasing system reset; must be >=1.
CNT_W, 16, width of the shared phase counter; all three cycle parameters must be <= 2^CNT_W.
LOSS_W, 8, width of the lock-loss event counter.

Ports:
clock  in  1  board reference clock (same clock that feeds the PLL REFERENCECLK)
rst_n  in  1  asynchronous active-low reset; clock is the only clock
pll_lock  in  1  PLL LOCK output, asynchronous to clock
relock_req  in  1  synchronous single-cycle request to restart the full sequence
pll_resetb  out  1  to PLL RESETB; 0 = PLL held in reset
sys_rst_n  out  1  active-low system reset for downstream logic; 1 only in RUN
ready  out  1  equals RUN state (registered, identical timing to sys_rst_n)
state  out  2  current state: 0 PLL_RESET, 1 WAIT_LOCK, 2 STABILIZE, 3 RUN
lock_loss_count  out  LOSS_W  number of RUN->PLL_RESET transitions caused by lock drop; saturates at all-ones
timeout_seen  out  1  sticky; set on any WAIT_LOCK timeout; cleared only by rst_n

Behaviour:
- Reset (rst_n=0, async) forces the following values:
  - state=PLL_RESET, pll_resetb=0, sys_rst_n=0, ready=0.
  - Counter=0, lock_loss_count=0, timeout_seen=0.
  - Both lock synchronizer flops=0.
- pll_lock passes through a free-running 2-flop synchronizer, giving lock_s. lock_s lags pll_lock by 2 edges. Only lock_s is used by the FSM.
- All outputs are registered and decoded from the state register. There are no combinational paths from inputs to outputs.
- One counter, width CNT_W, clears to 0 on every state transition.
- PLL_RESET:
  - pll_resetb=0.
  - Counter increments each cycle.
  - When counter==RESET_CYCLES-1, go to WAIT_LOCK. The state lasts exactly RESET_CYCLES cycles.
- WAIT_LOCK:
  - pll_resetb=1.
  - If lock_s=1, go to STABILIZE.
  - Otherwise, if counter==LOCK_TIMEOUT-1, go to PLL_RESET and set timeout_seen.
  - Otherwise the counter increments.
- STABILIZE:
  - If lock_s=0, go to WAIT_LOCK (the timeout window restarts from 0).
  - Otherwise, if counter==STABLE_CYCLES-1, go to RUN.
  - Otherwise the counter increments. The state lasts exactly STABLE_CYCLES cycles when lock holds.
- RUN:
  - sys_rst_n=1, ready=1.
  - If lock_s=0, go to PLL_RESET and increment lock_loss_count (saturating).
  - The counter is idle at 0.
- relock_req=1 in any state:
  - Go to PLL_RESET with counter=0 on the next edge.
  - It has priority over every other transition in the same cycle.
  - It does not increment lock_loss_count, even when lock drops in the same cycle.
  - It does not set timeout_seen, even when a timeout falls in the same cycle.
  - relock_req while already in PLL_RESET restarts the reset window.
- Simultaneous events in STABILIZE: lock drop on the final count cycle goes to WAIT_LOCK, not RUN. Lock drop has priority over count completion.
- Simultaneous events in WAIT_LOCK: lock_s=1 on the timeout cycle goes to STABILIZE. Lock has priority over timeout, and timeout_seen is not set.
- lock_s is not masked during PLL_RESET. A stale high lock is handled by the STABILIZE qualification.
- Mid-operation rst_n assertion returns all outputs to their reset values immediately, including sys_rst_n=0 asynchronously.

Test Plan:
All scenarios use RESET_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, LOSS_W=2; edges are counted from rst_n release.
1. Clean bring-up, pll_lock tied 1:
   - pll_resetb=0 for edges 0-3, 1 from edge 4.
   - state goes WAIT_LOCK at 4, STABILIZE at 5, RUN at 13.
   - sys_rst_n=ready=1 from edge 13; lock_loss_count=0.
2. Lock timeout, pll_lock held 0:
   - WAIT_LOCK runs 32 cycles, then PLL_RESET 4 cycles; the cycle repeats.
   - timeout_seen=1 after the first timeout; sys_rst_n stays 0.
   - pll_lock raised later -> RUN after 2+1+8 edges; timeout_seen stays 1.
3. Lock glitch in STABILIZE: from scenario 1, drop pll_lock for 1 cycle at edge 9.
   - Returns to WAIT_LOCK, then re-enters STABILIZE.
   - RUN entered 8 full lock cycles later; lock_loss_count=0.
4. Lock loss in RUN: drop pll_lock 4 times, re-locking between drops.
   - lock_loss_count goes 1, 2, 3, 3 (saturates).
   - Each drop produces sys_rst_n=0 two edges later (synchronizer) plus one edge (state register), followed by a full 4-cycle PLL reset.
5. relock_req in RUN with pll_lock dropping in the same cycle:
   - PLL_RESET next edge; lock_loss_count unchanged.
   - relock_req again at PLL_RESET counter=2 -> pll_resetb stays 0 for 4 further cycles.
6. rst_n asserted mid-STABILIZE and mid-RUN:
   - All outputs are at their reset values before the next clock edge.
   - The sequence restarts from PLL_RESET identically to scenario 1.

Source files
------------

// File: rtl/pll_reset_ctrl.sv
// pll_reset_ctrl: sequences the iCE40 PLL reset, waits for lock, qualifies
// lock as stable and only then releases the downstream system reset.
// Runs on the board reference clock; recovers from lock loss, lock timeout
// and software relock requests without outside help.
module pll_reset_ctrl #(
  parameter int RESET_CYCLES  = 16,
  parameter int LOCK_TIMEOUT  = 4096,
  parameter int STABLE_CYCLES = 256,
  parameter int CNT_W         = 16,
  parameter int LOSS_W        = 8
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              pll_lock,
  input  logic              relock_req,
  output logic              pll_resetb,
  output logic              sys_rst_n,
  output logic              ready,
  output logic [1:0]        state,
  output logic [LOSS_W-1:0] lock_loss_count,
  output logic              timeout_seen
);

  typedef enum logic [1:0] {
    ST_PLL_RESET = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_STABILIZE = 2'd2,
    ST_RUN       = 2'd3
  } state_t;

  // Terminal counts; the counter starts at 0 on entry to each phase.
  localparam logic [CNT_W-1:0] RESET_LAST   = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);

  state_t           state_q;
  state_t           state_next;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_next;
  logic             lock_meta;
  logic             lock_s;
  logic             loss_event;
  logic             timeout_event;

  // Free-running two-flop synchronizer for the asynchronous PLL lock.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= pll_lock;
      lock_s    <= lock_meta;
    end
  end

  // Next-state and counter logic; relock_req overrides every other transition.
  always_comb begin
    state_next    = state_q;
    cnt_next      = cnt_q;
    loss_event    = 1'b0;
    timeout_event = 1'b0;
    if (relock_req) begin
      state_next = ST_PLL_RESET;
      cnt_next   = '0;
    end else begin
      case (state_q)
        ST_PLL_RESET: begin
          if (cnt_q == RESET_LAST) begin
            state_next = ST_WAIT_LOCK;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_q + 1'b1;
          end
        end
        ST_WAIT_LOCK: begin
          // Lock wins over a timeout landing in the same cycle.
          if (lock_s) begin
            state_next = ST_STABILIZE;
            cnt_next   = '0;
          end else if (cnt_q == TIMEOUT_LAST) begin
            state_next    = ST_PLL_RESET;
            cnt_next      = '0;
            timeout_event = 1'b1;
          end else begin
            cnt_next = cnt_q + 1'b1;
          end
        end
        ST_STABILIZE: begin
          // A lock drop on the final count cycle still disqualifies.
          if (!lock_s) begin
            state_next = ST_WAIT_LOCK;
            cnt_next   = '0;
          end else if (cnt_q == STABLE_LAST) begin
            state_next = ST_RUN;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_q + 1'b1;
          end
        end
        ST_RUN: begin
          cnt_next = '0;
          if (!lock_s) begin
            state_next = ST_PLL_RESET;
            loss_event = 1'b1;
          end
        end
        default: begin
          state_next = ST_PLL_RESET;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // State, counter and outputs; outputs are decoded from the next state so
  // they change on the same edge as the state register.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_PLL_RESET;
      cnt_q           <= '0;
      pll_resetb      <= 1'b0;
      sys_rst_n       <= 1'b0;
      ready           <= 1'b0;
      lock_loss_count <= '0;
      timeout_seen    <= 1'b0;
    end else begin
      state_q    <= state_next;
      cnt_q      <= cnt_next;
      pll_resetb <= (state_next != ST_PLL_RESET);
      sys_rst_n  <= (state_next == ST_RUN);
      ready      <= (state_next == ST_RUN);
      if (loss_event && (lock_loss_count != {LOSS_W{1'b1}})) begin
        lock_loss_count <= lock_loss_count + 1'b1;
      end
      if (timeout_event) begin
        timeout_seen <= 1'b1;
      end
    end
  end

  assign state = state_q;

endmodule
